// File: rtl/rr_arb3.sv
// rr_arb3: three-requester round-robin arbiter with a fixed REQ2GNT-cycle grant pipeline
module rr_arb3 #(
  parameter int REQ2GNT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic [1:0] gnt_id,
  output logic [1:0] ptr
);
  logic [REQ2GNT-1:0][1:0] pipe;
  logic [3:0] rv;
  logic [1:0] c0, c1, c2, win;
  function automatic logic [1:0] nxt(input logic [1:0] k);
    return (k == 2'd3) ? 2'd1 : k + 2'd1;
  endfunction
  always_comb begin
    rv  = {req3, req2, req1, 1'b0};
    c0  = ptr;
    c1  = nxt(c0);
    c2  = nxt(c1);
    win = rv[c0] ? c0 : rv[c1] ? c1 : rv[c2] ? c2 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr  <= 2'd1;
      pipe <= '0;
    end else begin
      pipe[0] <= win;
      for (int i = 1; i < REQ2GNT; i++) pipe[i] <= pipe[i-1];
      if (win != 2'd0) ptr <= nxt(win);
    end
  end
  assign gnt_id = pipe[REQ2GNT-1];
  assign gnt1   = (gnt_id == 2'd1);
  assign gnt2   = (gnt_id == 2'd2);
  assign gnt3   = (gnt_id == 2'd3);
endmodule

// File: tb/tb_rr_arb3.sv
// tb_rr_arb3: directed and randomized checks of rr_arb3 at latency 2 and 1 against a reference model
module tb_rr_arb3;
  logic clk = 0, resetn = 0, req1 = 0, req2 = 0, req3 = 0;
  logic g1a, g2a, g3a, g1b, g2b, g3b;
  logic [1:0] ida, ptra, idb, ptrb;
  int checks = 0, errors = 0;
  int mptr = 1;
  int hist [8];

  always #5 clk = ~clk;

  rr_arb3 #(.REQ2GNT(2)) u2 (.clk(clk), .resetn(resetn), .req1(req1), .req2(req2), .req3(req3),
    .gnt1(g1a), .gnt2(g2a), .gnt3(g3a), .gnt_id(ida), .ptr(ptra));
  rr_arb3 #(.REQ2GNT(1)) u1 (.clk(clk), .resetn(resetn), .req1(req1), .req2(req2), .req3(req3),
    .gnt1(g1b), .gnt2(g2b), .gnt3(g3b), .gnt_id(idb), .ptr(ptrb));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic r1, input logic r2, input logic r3);
    resetn = rn; req1 = r1; req2 = r2; req3 = r3;
    if (!rn) begin
      mptr = 1;
      foreach (hist[i]) hist[i] = 0;
    end else begin
      int w = 0;
      for (int o = 0; o < 3; o++) begin
        int c = (mptr - 1 + o) % 3 + 1;
        if (w == 0 && (c == 1 ? r1 : c == 2 ? r2 : r3)) w = c;
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = w;
      if (w != 0) mptr = w % 3 + 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("id_l2", ida, hist[1]);
    chk("onehot_l2", {g3a, g2a, g1a}, hist[1] == 0 ? 0 : 1 << (hist[1] - 1));
    chk("ptr_l2", ptra, mptr);
    chk("id_l1", idb, hist[0]);
    chk("onehot_l1", {g3b, g2b, g1b}, hist[0] == 0 ? 0 : 1 << (hist[0] - 1));
    chk("ptr_l1", ptrb, mptr);
  endtask

  initial begin
    repeat (3) step(0, 1, 1, 1);
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (9) step(1, 1, 1, 1);
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (400) step($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) step(1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
